alu_exec_unit: RTL and testbench

//  Execute-stage ALU consuming the 3-bit ALUCtrl code produced by the ALU control

---
 rtl/alu_exec_unit.sv | 116 +++++++++++
 tb/tb_alu_exec_unit.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle AND/OR/ADD/SUB, iterative shift-add MUL over WIDTH cycles.
// Result, zero flag and a one-cycle valid pulse are registered for the EX/MEM stage.
module alu_exec_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [2:0]       ALUCtrl_i,
    input  logic [WIDTH-1:0] data1_i,
    input  logic [WIDTH-1:0] data2_i,
    output logic [WIDTH-1:0] data_o,
    output logic             Zero_o,
    output logic             valid_o,
    output logic             busy_o
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic {
        IDLE,
        MUL
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
    logic [WIDTH-1:0] alu_res;
    logic [CW-1:0]    count;
    logic             alu_defined;
    logic             is_mul;
    logic             accept;
    logic             last_iter;

    always_comb begin
        alu_res     = '0;
        alu_defined = 1'b1;
        is_mul      = 1'b0;
        case (ALUCtrl_i)
            3'b000:  alu_res = data1_i & data2_i;
            3'b001:  alu_res = data1_i | data2_i;
            3'b010:  alu_res = data1_i + data2_i;
            3'b011:  alu_res = data1_i - data2_i;
            3'b110:  is_mul = 1'b1;
            default: alu_defined = 1'b0;
        endcase
    end

    always_comb begin
        acc_next  = mplier[0] ? acc + mcand : acc;
        last_iter = (count == CW'(WIDTH - 1));
        accept    = (state == IDLE) && start_i;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (accept && is_mul) next_state = MUL;
            MUL:  if (last_iter) next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= IDLE;
        else       state <= next_state;
    end

    assign busy_o = (state == MUL);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_o  <= '0;
            Zero_o  <= 1'b1;
            valid_o <= 1'b0;
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            count   <= '0;
        end else begin
            valid_o <= 1'b0;
            if (state == IDLE) begin
                if (accept) begin
                    if (is_mul) begin
                        mcand  <= data1_i;
                        mplier <= data2_i;
                        acc    <= '0;
                        count  <= '0;
                    end else if (alu_defined) begin
                        data_o  <= alu_res;
                        Zero_o  <= (alu_res == '0);
                        valid_o <= 1'b1;
                    end else begin
                        data_o  <= '0;
                        Zero_o  <= 1'b1;
                        valid_o <= 1'b1;
                    end
                end
            end else begin
                // Final iteration publishes the sum directly so the result lands with the state change.
                acc    <= acc_next;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                count  <= count + 1'b1;
                if (last_iter) begin
                    data_o  <= acc_next;
                    Zero_o  <= (acc_next == '0);
                    valid_o <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit (WIDTH=32).
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_alu_exec_unit;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [2:0]       ctrl;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] data;
    logic             zero;
    logic             valid;
    logic             busy;

    int               n_checks = 0;
    int               n_errors = 0;
    logic [WIDTH-1:0] held;

    always #5 clk = ~clk;

    alu_exec_unit #(.WIDTH(WIDTH)) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .start_i  (start),
        .ALUCtrl_i(ctrl),
        .data1_i  (a),
        .data2_i  (b),
        .data_o   (data),
        .Zero_o   (zero),
        .valid_o  (valid),
        .busy_o   (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic alu_op(input string tag, input logic [2:0] code, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] r, input logic z);
        start = 1'b1;
        ctrl  = code;
        a     = x;
        b     = y;
        step();
        start = 1'b0;
        check({tag, " data"}, data, r);
        check({tag, " zero"}, 32'(zero), 32'(z));
        check({tag, " valid"}, 32'(valid), 32'd1);
        check({tag, " busy"}, 32'(busy), 32'd0);
        step();
        check({tag, " valid pulse"}, 32'(valid), 32'd0);
        check({tag, " hold"}, data, r);
        held = r;
    endtask

    task automatic mul_op(input string tag, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] r, input logic z, input bit disturb, input bit chain);
        int busy_cycles;
        int extra_valid;
        start = 1'b1;
        ctrl  = 3'b110;
        a     = x;
        b     = y;
        step();
        start = 1'b0;
        check({tag, " hold during mul"}, data, held);
        busy_cycles = 0;
        extra_valid = 0;
        for (int i = 0; i < WIDTH + 4 && busy === 1'b1; i++) begin
            busy_cycles++;
            if (valid !== 1'b0) extra_valid++;
            if (disturb) begin
                start = 1'($urandom_range(0, 1));
                ctrl  = 3'b010;
                a     = $urandom;
                b     = $urandom;
            end
            step();
        end
        start = 1'b0;
        check({tag, " busy cycles"}, 32'(busy_cycles), 32'(WIDTH));
        check({tag, " valid while busy"}, 32'(extra_valid), 32'd0);
        check({tag, " data"}, data, r);
        check({tag, " zero"}, 32'(zero), 32'(z));
        check({tag, " valid"}, 32'(valid), 32'd1);
        check({tag, " busy end"}, 32'(busy), 32'd0);
        held = r;
        if (!chain) begin
            step();
            check({tag, " valid pulse"}, 32'(valid), 32'd0);
            check({tag, " hold"}, data, r);
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        ctrl  = 3'b000;
        a     = '0;
        b     = '0;
        held  = '0;
        step();
        step();
        check("reset data", data, 32'd0);
        check("reset zero", 32'(zero), 32'd1);
        check("reset valid", 32'(valid), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        rst = 1'b0;
        step();
        check("idle no valid", 32'(valid), 32'd0);

        alu_op("add 5+7", 3'b010, 32'd5, 32'd7, 32'd12, 1'b0);
        alu_op("sub 3-5", 3'b011, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b0);
        alu_op("sub 9-9", 3'b011, 32'd9, 32'd9, 32'd0, 1'b1);
        alu_op("and", 3'b000, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_00F0, 1'b0);
        alu_op("or", 3'b001, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_FFF0, 1'b0);
        alu_op("add wrap", 3'b010, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1);

        mul_op("mul 6*7", 32'd6, 32'd7, 32'd42, 1'b0, 1'b0, 1'b0);
        mul_op("mul ffffffff*2", 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
        mul_op("mul 10000^2", 32'h0001_0000, 32'h0001_0000, 32'd0, 1'b1, 1'b0, 1'b0);
        mul_op("mul 6*7 disturbed", 32'd6, 32'd7, 32'd42, 1'b0, 1'b1, 1'b0);

        mul_op("b2b mul 3*4", 32'd3, 32'd4, 32'd12, 1'b0, 1'b0, 1'b1);
        alu_op("b2b add 1+2", 3'b010, 32'd1, 32'd2, 32'd3, 1'b0);

        alu_op("undef 111", 3'b111, 32'd5, 32'd6, 32'd0, 1'b1);
        alu_op("undef 100", 3'b100, 32'd5, 32'd6, 32'd0, 1'b1);
        alu_op("add before rst", 3'b010, 32'd5, 32'd7, 32'd12, 1'b0);

        start = 1'b1;
        ctrl  = 3'b110;
        a     = 32'd6;
        b     = 32'd7;
        step();
        start = 1'b0;
        repeat (10) step();
        check("mid-mul busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("mid-mul rst data", data, 32'd0);
        check("mid-mul rst zero", 32'(zero), 32'd1);
        check("mid-mul rst valid", 32'(valid), 32'd0);
        check("mid-mul rst busy", 32'(busy), 32'd0);
        step();
        step();
        check("rst held valid", 32'(valid), 32'd0);
        rst = 1'b0;
        step();
        check("after rst valid", 32'(valid), 32'd0);
        check("after rst busy", 32'(busy), 32'd0);
        held = '0;
        alu_op("post-rst add 1+1", 3'b010, 32'd1, 32'd1, 32'd2, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
